// File: rtl/ftm_pkg.sv
// ----------------------------------------------------------------------------
// ftm_pkg
// Shared constants and types for the fault-tolerance checkpoint store.
//   FtmNumRegs       : default number of architectural registers (x0..x31)
//   FtmPcOffset      : word offset of the checkpointed PC in the read map
//   FtmStatusOffset  : word offset of the status word in the read map
//   FtmMaxOffset     : highest decoded word offset; anything above errors
//   ftm_status_t     : layout of the status word returned at FtmStatusOffset
// ----------------------------------------------------------------------------
package ftm_pkg;

  localparam int FtmNumRegs = 32;

  localparam logic [5:0] FtmPcOffset     = 6'd32;
  localparam logic [5:0] FtmStatusOffset = 6'd33;
  localparam logic [5:0] FtmMaxOffset    = 6'd33;

  // Status word: commit count in the top half, ckpt-valid flag in bit 0.
  typedef struct packed {
    logic [15:0] count;
    logic [14:0] reserved;
    logic        ckptValid;
  } ftm_status_t;

endpackage

// File: rtl/ftm_reg_bank.sv
// ----------------------------------------------------------------------------
// ftm_reg_bank
// Bank of registers x1..x(NumRegs-1), 32 bits each, all flops. x0 is not
// stored; callers treat it as constant zero.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears the bank)
//   we_i          : single write port enable
//   waddr_i       : write address (0 is ignored, there is no x0 storage)
//   wdata_i       : write data
//   load_i        : bulk load of the whole bank; wins over the write port
//   load_data_i   : image loaded when load_i is set
//   regs_o        : combinational view of every stored register
// ----------------------------------------------------------------------------
module ftm_reg_bank
  import ftm_pkg::*;
#(
  parameter int NumRegs = FtmNumRegs
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [4:0]                waddr_i,
  input  logic [31:0]               wdata_i,
  input  logic                      load_i,
  input  logic [NumRegs-1:1][31:0]  load_data_i,
  output logic [NumRegs-1:1][31:0]  regs_o
);

  logic [NumRegs-1:1][31:0] regs_q;
  logic [NumRegs-1:1][31:0] regs_d;

  // Next bank image: a bulk load replaces everything, otherwise the single
  // write port updates at most one register. Address 0 matches no entry.
  always_comb begin
    regs_d = regs_q;
    if (load_i) begin
      regs_d = load_data_i;
    end else if (we_i) begin
      for (int i = 1; i < NumRegs; i++) begin
        if (waddr_i == 5'(i)) begin
          regs_d[i] = wdata_i;
        end
      end
    end
  end

  // Bank storage, cleared to zero on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/ftm_checkpoint_mem.sv
// ----------------------------------------------------------------------------
// ftm_checkpoint_mem
// Checkpoint store for the fault-tolerance module. Core 0's register-file
// writes are snooped into a staging bank; a comparator commit copies staging
// into the checkpoint bank, a mismatch reverts staging from the checkpoint.
// During recovery the cores read the checkpoint through a simple data port.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   we_i/waddr_i/wdata_i : snooped register-file write port
//   pc_i                 : PC captured on commit
//   commit_i, discard_i  : comparator pass / mismatch (discard wins)
//   recovering_i         : enables the data port
//   data_req_i/gnt_o     : request / combinational grant
//   data_we_i            : write request, always answered with an error
//   data_be_i            : byte enables, ignored
//   data_addr_i          : word address, only [7:2] decoded, [1:0] must be 0
//   data_wdata_i         : unused
//   data_rvalid_o        : one-cycle response strobe, one cycle after grant
//   data_rdata_o/err_o   : response payload, held while rvalid is low
//   ckpt_valid_o         : at least one commit seen since reset
// ----------------------------------------------------------------------------
module ftm_checkpoint_mem
  import ftm_pkg::*;
#(
  parameter int NumRegs  = FtmNumRegs,
  parameter int CntWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] pc_i,
  input  logic        commit_i,
  input  logic        discard_i,
  input  logic        recovering_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ckpt_valid_o
);

  logic [NumRegs-1:1][31:0] stageRegs;
  logic [NumRegs-1:1][31:0] ckptRegs;

  logic                commitEn;
  logic                stageWe;
  logic [31:0]         ckptPc_q, ckptPc_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                ckptValid_q, ckptValid_d;

  logic [5:0]          offset;
  logic                reqErr;
  logic [31:0]         readWord;
  ftm_status_t         status;

  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                unused_inputs;

  // A discard overrides both a same-cycle commit and a same-cycle snoop write.
  assign commitEn = commit_i & ~discard_i;
  assign stageWe  = we_i & ~discard_i;

  ftm_reg_bank #(.NumRegs(NumRegs)) u_stage (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .we_i        (stageWe),
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .load_i      (discard_i),
    .load_data_i (ckptRegs),
    .regs_o      (stageRegs)
  );

  // The checkpoint bank is only ever bulk-loaded from staging as it stood
  // before the commit edge, so a same-cycle snoop write lands in staging only.
  ftm_reg_bank #(.NumRegs(NumRegs)) u_ckpt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .we_i        (1'b0),
    .waddr_i     (5'd0),
    .wdata_i     (32'd0),
    .load_i      (commitEn),
    .load_data_i (stageRegs),
    .regs_o      (ckptRegs)
  );

  // Commit bookkeeping: PC capture, wrapping commit counter, valid flag.
  always_comb begin
    ckptPc_d    = ckptPc_q;
    cnt_d       = cnt_q;
    ckptValid_d = ckptValid_q;
    if (commitEn) begin
      ckptPc_d    = pc_i;
      cnt_d       = cnt_q + CntWidth'(1);
      ckptValid_d = 1'b1;
    end
  end

  // Read decode. Offsets 1..31 map to the checkpoint bank, offset 0 is x0.
  assign offset = data_addr_i[7:2];
  assign reqErr = data_we_i | (offset > FtmMaxOffset) | (data_addr_i[1:0] != 2'b00);

  assign status.count     = 16'(cnt_q);
  assign status.reserved  = '0;
  assign status.ckptValid = ckptValid_q;

  always_comb begin
    readWord = '0;
    if (offset == FtmPcOffset) begin
      readWord = ckptPc_q;
    end else if (offset == FtmStatusOffset) begin
      readWord = status;
    end else begin
      for (int i = 1; i < NumRegs; i++) begin
        if (offset == 6'(i)) begin
          readWord = ckptRegs[i];
        end
      end
    end
  end

  // Grant is purely combinational; every grant produces one response next
  // cycle. Payload is captured from the checkpoint at the grant edge, so a
  // commit or discard on that same edge cannot alter it. Payload holds
  // between responses.
  assign data_gnt_o = data_req_i & recovering_i;

  always_comb begin
    rvalid_d = data_gnt_o;
    err_d    = err_q;
    rdata_d  = rdata_q;
    if (data_gnt_o) begin
      err_d   = reqErr;
      rdata_d = reqErr ? 32'd0 : readWord;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ckptPc_q    <= '0;
      cnt_q       <= '0;
      ckptValid_q <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ckptPc_q    <= ckptPc_d;
      cnt_q       <= cnt_d;
      ckptValid_q <= ckptValid_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign ckpt_valid_o  = ckptValid_q;

  // Inputs that the port carries but this store never looks at.
  assign unused_inputs = ^{data_be_i, data_wdata_i, data_addr_i[31:8]};

endmodule

// File: tb/tb_ftm_checkpoint_mem.sv
// ----------------------------------------------------------------------------
// tb_ftm_checkpoint_mem
// Self-checking bench for ftm_checkpoint_mem: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized phase, all checked
// against an array-based reference model of the checkpoint store.
// ----------------------------------------------------------------------------
module tb_ftm_checkpoint_mem;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [31:0] pc_i;
  logic        commit_i;
  logic        discard_i;
  logic        recovering_i;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        ckpt_valid_o;

  ftm_checkpoint_mem dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .pc_i          (pc_i),
    .commit_i      (commit_i),
    .discard_i     (discard_i),
    .recovering_i  (recovering_i),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .ckpt_valid_o  (ckpt_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        commit;
    logic        discard;
    logic        rec;
    logic        req;
    logic        dwe;
    logic [31:0] addr;
    logic        expGnt;
    logic        expRvalid;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  localparam int NumVecs = 24;
  vec_t vecs [NumVecs];

  int checks = 0;
  int passes = 0;

  // Reference model: staging/checkpoint arrays, PC, counter and valid flag.
  logic [31:0] mS [32];
  logic [31:0] mC [32];
  logic [31:0] mPc;
  logic [15:0] mCnt;
  logic        mValid;

  function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] pc, input logic commit, input logic discard,
                              input logic rec, input logic req, input logic dwe, input logic [31:0] addr,
                              input logic eg, input logic ev, input logic ee, input logic [31:0] ed);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.pc = pc;
    v.commit = commit; v.discard = discard; v.rec = rec; v.req = req;
    v.dwe = dwe; v.addr = addr;
    v.expGnt = eg; v.expRvalid = ev; v.expErr = ee; v.expRdata = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    we_i         = v.we;
    waddr_i      = v.waddr;
    wdata_i      = v.wdata;
    pc_i         = v.pc;
    commit_i     = v.commit;
    discard_i    = v.discard;
    recovering_i = v.rec;
    data_req_i   = v.req;
    data_we_i    = v.dwe;
    data_addr_i  = v.addr;
    data_be_i    = 4'hF;
    data_wdata_i = 32'h5A5A_5A5A;
    #1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mS[i] = '0;
      mC[i] = '0;
    end
    mPc = '0; mCnt = '0; mValid = 1'b0;
  endtask

  // Response the store must give for a read of addr, from the model state.
  function automatic logic [32:0] modelRead(input logic [31:0] addr, input logic we);
    logic [5:0] off;
    off = addr[7:2];
    if (we || addr[1:0] != 2'b00 || off > 6'd33) return {1'b1, 32'd0};
    if (off == 6'd32) return {1'b0, mPc};
    if (off == 6'd33) return {1'b0, mCnt, 15'd0, mValid};
    if (off == 6'd0) return {1'b0, 32'd0};
    return {1'b0, mC[off[4:0]]};
  endfunction

  task automatic modelEdge();
    if (discard_i) begin
      for (int i = 1; i < 32; i++) mS[i] = mC[i];
    end else begin
      if (commit_i) begin
        for (int i = 1; i < 32; i++) mC[i] = mS[i];
        mPc = pc_i;
        mCnt = mCnt + 16'd1;
        mValid = 1'b1;
      end
      if (we_i && waddr_i != 5'd0) mS[waddr_i] = wdata_i;
    end
  endtask

  // One clock cycle with the currently applied inputs, checked against the model.
  task automatic cycle();
    logic        expGnt;
    logic [32:0] rsp;
    expGnt = data_req_i & recovering_i;
    checkOutput("gnt", 32'(data_gnt_o), 32'(expGnt));
    rsp = modelRead(data_addr_i, data_we_i);
    @(posedge clk_i);
    modelEdge();
    #1;
    checkOutput("rvalid", 32'(data_rvalid_o), 32'(expGnt));
    if (expGnt) begin
      checkOutput("err", 32'(data_err_o), 32'(rsp[32]));
      checkOutput("rdata", data_rdata_o, rsp[31:0]);
    end
    checkOutput("ckpt_valid", 32'(ckpt_valid_o), 32'(mValid));
  endtask

  function automatic vec_t idleVec(input logic rec);
    return mk(0, 0, 0, 0, 0, 0, rec, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t readVec(input logic [31:0] addr);
    return mk(0, 0, 0, 0, 0, 0, 1, 1, 0, addr, 0, 0, 0, 0);
  endfunction

  initial begin
    int   rvCount;
    vec_t v;

    // Reset state.
    rst_ni = 1'b0;
    applyStimulus(idleVec(0));
    modelReset();
    #1;
    checkOutput("reset rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("reset err", 32'(data_err_o), 32'd0);
    checkOutput("reset rdata", data_rdata_o, 32'd0);
    checkOutput("reset ckpt_valid", 32'(ckpt_valid_o), 32'd0);
    checkOutput("reset gnt", 32'(data_gnt_o), 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed vector table; expectations are the outputs after each row's edge.
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h80, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h14, 1, 1, 0, 32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h80, 1, 1, 0, 32'h80);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 3, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 3, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 32'h104, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0C, 1, 1, 0, 32'd1);
    vecs[11] = mk(0, 0, 0, 32'h999, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h84, 1, 1, 0, 32'h00030001);
    vecs[13] = mk(1, 7, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 7, 32'hB, 32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1C, 1, 1, 0, 32'hA);
    vecs[16] = mk(0, 0, 0, 32'h204, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1C, 1, 1, 0, 32'hB);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h14, 1, 1, 1, 32'd0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h88, 1, 1, 1, 32'd0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h02, 1, 1, 1, 32'd0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h84, 1, 1, 0, 32'h00050001);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h80, 1, 1, 0, 32'h204);

    for (int i = 0; i < NumVecs; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d gnt", i), 32'(data_gnt_o), 32'(vecs[i].expGnt));
      cycle();
      checkOutput($sformatf("row%0d rvalid", i), 32'(data_rvalid_o), 32'(vecs[i].expRvalid));
      if (vecs[i].expRvalid) begin
        checkOutput($sformatf("row%0d err", i), 32'(data_err_o), 32'(vecs[i].expErr));
        checkOutput($sformatf("row%0d rdata", i), data_rdata_o, vecs[i].expRdata);
      end
    end

    // Throughput: fill every register (plus an x0 write), commit, then
    // 32 back-to-back reads of offsets 0..31.
    for (int r = 1; r < 32; r++) begin
      applyStimulus(mk(1, 5'(r), $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      cycle();
    end
    applyStimulus(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    applyStimulus(mk(0, 0, 0, 32'h300, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    rvCount = 0;
    for (int r = 0; r < 32; r++) begin
      applyStimulus(readVec(32'(r * 4)));
      cycle();
      if (data_rvalid_o === 1'b1) rvCount++;
      if (r == 0) checkOutput("x0 reads zero", data_rdata_o, 32'd0);
    end
    checkOutput("back-to-back rvalid count", 32'(rvCount), 32'd32);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      v = idleVec(0);
      v.we      = 1'($urandom_range(0, 1));
      v.waddr   = 5'($urandom_range(0, 31));
      v.wdata   = $urandom;
      v.pc      = $urandom;
      v.commit  = ($urandom_range(0, 5) == 0);
      v.discard = ($urandom_range(0, 11) == 0);
      v.rec     = ($urandom_range(0, 3) != 0);
      v.req     = 1'($urandom_range(0, 1));
      v.dwe     = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 9))
        0:       v.addr = {24'd0, 8'($urandom_range(0, 255))};
        1:       v.addr = {$urandom, 2'b00} | 32'(6'($urandom_range(0, 33)) << 2);
        default: v.addr = 32'($urandom_range(0, 33)) << 2;
      endcase
      applyStimulus(v);
      cycle();
    end

    // Reset while a response is pending clears rvalid immediately.
    applyStimulus(readVec(32'h14));
    cycle();
    applyStimulus(idleVec(1));
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset rvalid", 32'(data_rvalid_o), 32'd0);
    checkOutput("mid reset ckpt_valid", 32'(ckpt_valid_o), 32'd0);
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("held reset rvalid", 32'(data_rvalid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    applyStimulus(readVec(32'h84));
    cycle();
    checkOutput("status after reset", data_rdata_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(mk(0, 0, 0, 32'(k), 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      cycle();
    end
    applyStimulus(readVec(32'h84));
    cycle();
    checkOutput("status after 3 commits", data_rdata_o, 32'h00030001);

    applyStimulus(idleVec(0));
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ftm_checkpoint_mem.md
# ftm_checkpoint_mem

Checkpoint store for the fault-tolerance module. It snoops core 0's register-file write port into a staging bank and copies staging into a checkpoint bank on each commit from the lockstep comparator. During recovery it serves the cores' data-memory read requests, so the debug-mode recovery routine can reload x1–x31 and the PC. It sits between the core write-back path (upstream) and the cores' recovery-mode data interface (downstream).

## Interface
Parameters:
- NumRegs, 32, architectural registers held; x0 is hard-wired to 0.
- CntWidth, 16, width of the commit counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- we_i  in  1  core 0 register-file write enable.
- waddr_i  in  5  register-file write address.
- wdata_i  in  32  register-file write data.
- pc_i  in  32  PC of the instruction being committed.
- commit_i  in  1  comparator pass; copy staging to checkpoint.
- discard_i  in  1  comparator mismatch; revert staging to checkpoint.
- recovering_i  in  1  recovery window active; enables the data port.
- data_req_i  in  1  request.
- data_gnt_o  out  1  grant.
- data_rvalid_o  out  1  response valid.
- data_we_i  in  1  write request (illegal).
- data_be_i  in  4  byte enables (ignored for reads).
- data_addr_i  in  32  address; only [7:2] decoded.
- data_wdata_i  in  32  unused.
- data_rdata_o  out  32  read data.
- data_err_o  out  1  error response, valid with rvalid.
- ckpt_valid_o  out  1  at least one commit since reset.

## Operation
- Staging bank S[1..31] and checkpoint bank C[1..31], plus S_pc/C_pc and a commit counter; all flops.
- Snoop: when we_i is set and waddr_i ≠ 0, S[waddr_i] ← wdata_i at the clock edge. Writes to x0 are dropped.
- commit_i (with discard_i low):
  - C ← S as held before this edge; a we_i in the same cycle still lands in S only.
  - C_pc ← pc_i.
  - Counter increments and wraps at 2^CntWidth.
  - ckpt_valid_o ← 1.
- discard_i: S ← C. Any same-cycle we_i is dropped. discard_i has priority over commit_i; when both are high, the commit is ignored.
- Snoop, commit and discard operate regardless of recovering_i.
- Address map (offset = data_addr_i[7:2]):
  - 0..31 → C[n]; offset 0 reads 0.
  - 32 (0x80) → C_pc.
  - 33 (0x84) → status: {counter[15:0], 15'b0, ckpt_valid}.
  - Above 33 → error.
- Data port: data_gnt_o = data_req_i & recovering_i (combinational). A granted request yields exactly one response on the next cycle.
- data_err_o = 1 with rdata = 0 on any of:
  - data_we_i = 1;
  - offset > 33;
  - data_addr_i[1:0] ≠ 0.
- Requests while recovering_i = 0 are never granted.
- Read data is sampled from C at the grant edge. A commit or discard in that same cycle does not affect the returned value.

## Timing
- Reset values: data_gnt_o follows its inputs (0 while req is low); data_rvalid_o, data_err_o, data_rdata_o, ckpt_valid_o are 0; both banks, both PC registers and the counter are 0.
- Read latency is 1 cycle: grant in cycle N, rvalid/rdata/err in cycle N+1 for exactly one cycle.
- Back-to-back grants are allowed; throughput is one request per cycle and there is no stall.
- rdata/err hold their last value when rvalid is 0; consumers must qualify them with rvalid.
- If recovering_i drops while a response is pending, the response is still delivered in the next cycle.
- Asynchronous reset mid-operation clears any pending rvalid immediately; no response is issued after reset.
- Bank updates become visible to reads one cycle after the write, commit or discard edge.

## Structure
- ftm_pkg holds:
  - FtmPcOffset = 6'd32, FtmStatusOffset = 6'd33, FtmMaxOffset = 6'd33;
  - NumRegs default;
  - the status-word layout struct.
- One sub-module, ftm_reg_bank: 31×32 flops with a single write port, a bulk-load input and combinational read. It is instantiated twice (staging and checkpoint). The top level holds the PC registers, counter, decode and response register.

## Test plan
- Snoop/commit: write x5 = 0xDEADBEEF, commit with pc_i = 0x80, raise recovering_i, read 0x14 and 0x80 → rdata 0xDEADBEEF then 0x00000080, err 0, each one cycle after gnt.
- Discard: commit x3 = 1, write x3 = 2, discard, commit, read 0x0C → 1. Commit and discard in the same cycle → the commit is ignored and the counter is unchanged.
- Same-cycle commit and write: x7 staged as 0xA, then commit with we_i writing x7 = 0xB → C[7] = 0xA; a second commit → 0xB.
- Errors: data_we_i = 1, address 0x88, or address 0x02 → gnt 1, rvalid 1 with err 1 and rdata 0. A request with recovering_i = 0 → gnt 0 and no rvalid.
- Throughput: 32 consecutive reads of 0x00–0x7C → 32 consecutive rvalid cycles with correct data; x0 reads 0 even after waddr = 0 writes.
- Reset: assert rst_ni low in the cycle after a grant → rvalid 0 immediately. Status then reads 0 once recovering, and ckpt_valid_o = 0. After 3 commits, status reads 0x00030001.
